// File: rtl/alu_m_defs.sv
// Shared definitions for the RV32M sequential execution unit.
// Holds M-extension decode constants and FSM state encodings.
package alu_m_defs;

  localparam logic [6:0] OPCODE_M = 7'b0110011;
  localparam logic [6:0] FUNCT7_M = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_m_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// acc holds {hi, lo}; lo is the multiplier or the dividend being consumed.
module alu_m_step #(
  parameter int XLEN = 32
) (
  input  logic              opDiv,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] accNext
);

  logic [XLEN:0] sum;
  logic [XLEN:0] remSh;
  logic [XLEN:0] diff;

  always_comb begin
    sum   = {1'b0, acc[2*XLEN-1:XLEN]}
          + (acc[0] ? {1'b0, opnd} : '0);
    remSh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff  = remSh - {1'b0, opnd};
    // borrow out of the top bit means the trial subtract must be undone
    if (opDiv) begin
      if (diff[XLEN]) begin
        accNext = {remSh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end else begin
        accNext = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end
    end else begin
      accNext = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/alu_m_seq.sv
// Multi-cycle RV32M unit: magnitude iteration plus final sign fix.
// Divide-by-zero and signed overflow bypass the iteration entirely.
module alu_m_seq
  import alu_m_defs::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iVALID,
  input  logic [2:0]      iFUNCT3,
  input  logic [XLEN-1:0] iALU_IN1_M,
  input  logic [XLEN-1:0] iALU_IN2_M,
  input  logic            iKILL,
  output logic            oREADY,
  output logic            oBUSY,
  output logic            oVALID,
  output logic [XLEN-1:0] oALU_OUT_M
);

  localparam logic [XLEN-1:0] MinNeg =
    {1'b1, {(XLEN-1){1'b0}}};

  state_t stateQ, stateD;

  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc, accNext, prodS;
  logic [XLEN-1:0]   opnd, outQ;
  logic [2:0]        opQ;
  logic              negMain, negRem;

  logic            sgn1, sgn2;
  logic            divZero, ovf, special, accept;
  logic [XLEN-1:0] mag1, mag2, specialRes, fixRes;
  logic [XLEN-1:0] quot, rem;

  alu_m_step #(
    .XLEN(XLEN)
  ) uStep (
    .opDiv  (opQ[2]),
    .acc    (acc),
    .opnd   (opnd),
    .accNext(accNext)
  );

  always_comb begin
    sgn1 = iALU_IN1_M[XLEN-1] & (iFUNCT3 inside
      {F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
    sgn2 = iALU_IN2_M[XLEN-1] & (iFUNCT3 inside
      {F3_MULH, F3_DIV, F3_REM});
    mag1 = sgn1 ? -iALU_IN1_M : iALU_IN1_M;
    mag2 = sgn2 ? -iALU_IN2_M : iALU_IN2_M;
    divZero = iFUNCT3[2] & (iALU_IN2_M == '0);
    ovf = (iFUNCT3 inside {F3_DIV, F3_REM})
        & (iALU_IN1_M == MinNeg) & (&iALU_IN2_M);
    special = divZero | ovf;
    // funct3[1] separates REM* from DIV*
    if (iFUNCT3[1]) begin
      specialRes = divZero ? iALU_IN1_M : '0;
    end else begin
      specialRes = divZero ? '1 : MinNeg;
    end
    accept = (stateQ == IDLE) & iVALID & ~iKILL;
  end

  always_comb begin
    prodS  = negMain ? -acc : acc;
    quot   = acc[XLEN-1:0];
    rem    = acc[2*XLEN-1:XLEN];
    fixRes = '0;
    unique case (1'b1)
      (opQ == F3_MUL):
        fixRes = prodS[XLEN-1:0];
      (opQ inside {F3_MULH, F3_MULHSU, F3_MULHU}):
        fixRes = prodS[2*XLEN-1:XLEN];
      (opQ inside {F3_DIV, F3_DIVU}):
        fixRes = negMain ? -quot : quot;
      (opQ inside {F3_REM, F3_REMU}):
        fixRes = negRem ? -rem : rem;
      default:
        fixRes = '0;
    endcase
  end

  always_comb begin
    stateD = stateQ;
    oVALID = 1'b0;
    unique case (stateQ)
      IDLE: if (accept) stateD = special ? DONE : CALC;
      CALC: if (cnt == CNT_W'(XLEN-1)) stateD = FIX;
      FIX:  stateD = DONE;
      DONE: begin
        oVALID = 1'b1;
        stateD = IDLE;
      end
    endcase
    if (iKILL && stateQ != IDLE) begin
      stateD = IDLE;
      oVALID = 1'b0;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      stateQ  <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      opQ     <= '0;
      negMain <= 1'b0;
      negRem  <= 1'b0;
      outQ    <= '0;
    end else begin
      stateQ <= stateD;
      if (accept) begin
        opQ     <= iFUNCT3;
        cnt     <= '0;
        acc     <= {{XLEN{1'b0}}, mag1};
        opnd    <= mag2;
        negMain <= sgn1 ^ sgn2;
        negRem  <= sgn1;
        if (special) outQ <= specialRes;
      end else if (!iKILL) begin
        if (stateQ == CALC) begin
          acc <= accNext;
          cnt <= cnt + CNT_W'(1);
        end
        if (stateQ == FIX) outQ <= fixRes;
      end
    end
  end

  assign oREADY     = (stateQ == IDLE);
  assign oBUSY      = (stateQ != IDLE);
  assign oALU_OUT_M = outQ;

endmodule

// File: tb/tb_alu_m_seq.sv
// Scoreboard bench for alu_m_seq against a 64-bit arithmetic model.
module tb_alu_m_seq;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iVALID = 1'b0;
  logic        iKILL = 1'b0;
  logic [2:0]  iFUNCT3 = '0;
  logic [31:0] iALU_IN1_M = '0;
  logic [31:0] iALU_IN2_M = '0;
  logic        oREADY, oBUSY, oVALID;
  logic [31:0] oALU_OUT_M;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t        sbQ[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          readyCyc = 0;
  logic [31:0] lastExp = '0;
  bit          running = 1'b0;

  alu_m_seq #(
    .XLEN (32),
    .CNT_W(6)
  ) dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iVALID    (iVALID),
    .iFUNCT3   (iFUNCT3),
    .iALU_IN1_M(iALU_IN1_M),
    .iALU_IN2_M(iALU_IN2_M),
    .iKILL     (iKILL),
    .oREADY    (oREADY),
    .oBUSY     (oBUSY),
    .oVALID    (oVALID),
    .oALU_OUT_M(oALU_OUT_M)
  );

  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cyc=%0d",
               name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] model(
    input logic [2:0] f, input logic [31:0] a,
    input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    p = '0;
    r = '0;
    case (f)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * $signed(ub); r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          r = 32'h0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int latency(
    input logic [2:0] f, input logic [31:0] a,
    input logic [31:0] b);
    bit fast;
    fast = f[2] && (b == 0 || (!f[0] &&
           a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    return fast ? 1 : 34;
  endfunction

  task automatic pushExp(input logic [2:0] f,
                         input logic [31:0] a,
                         input logic [31:0] b, input int t);
    exp_t e;
    int lat;
    lat = latency(f, a, b);
    e.val = model(f, a, b);
    e.cyc = t + lat;
    sbQ.push_back(e);
    readyCyc = t + lat + 1;
  endtask

  task automatic scramble();
    iFUNCT3    = 3'($urandom);
    iALU_IN1_M = $urandom;
    iALU_IN2_M = $urandom;
  endtask

  task automatic issue(input logic [2:0] f,
                       input logic [31:0] a,
                       input logic [31:0] b, output int t);
    int guard = 0;
    @(posedge iCLK); #1;
    while (!oREADY && guard < 200) begin
      @(posedge iCLK); #1;
      guard++;
    end
    check(oREADY, "ready_timeout", 32'(guard), 32'd200);
    iVALID = 1'b1;
    iFUNCT3 = f;
    iALU_IN1_M = a;
    iALU_IN2_M = b;
    t = cyc;
    @(posedge iCLK); #1;
    iVALID = 1'b0;
    scramble();
    pushExp(f, a, b, t);
  endtask

  task automatic randOp(output logic [2:0] f,
                        output logic [31:0] a,
                        output logic [31:0] b);
    int r;
    r = $urandom_range(0, 5);
    f = 3'($urandom_range(0, 7));
    a = $urandom;
    b = $urandom;
    case (r)
      0: b = 32'h0;
      1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      2: begin
        a = $urandom_range(0, 300);
        b = $urandom_range(0, 20);
      end
      3: a = 32'(-$urandom_range(1, 1000));
      default: ;
    endcase
  endtask

  // iVALID stays high throughout; inputs churn while busy
  task automatic stream(input int n);
    int got = 0;
    int guard = 0;
    int t = 0;
    bit pend = 1'b0;
    logic [2:0] f;
    logic [31:0] a, b;
    f = '0; a = '0; b = '0;
    @(posedge iCLK); #1;
    iVALID = 1'b1;
    while (got < n && guard < 3000) begin
      if (pend) begin
        pushExp(f, a, b, t);
        got++;
        pend = 1'b0;
      end
      if (got < n && oREADY) begin
        randOp(f, a, b);
        iFUNCT3 = f;
        iALU_IN1_M = a;
        iALU_IN2_M = b;
        t = cyc;
        pend = 1'b1;
      end else begin
        scramble();
      end
      @(posedge iCLK); #1;
      guard++;
    end
    iVALID = 1'b0;
    check(got == n, "stream_timeout", 32'(got), 32'(n));
  endtask

  task automatic rstChecks(input string tag);
    check(oREADY == 1'b1, {tag, "_ready"}, 32'(oREADY), 32'd1);
    check(oBUSY == 1'b0, {tag, "_busy"}, 32'(oBUSY), 32'd0);
    check(oVALID == 1'b0, {tag, "_valid"}, 32'(oVALID), 32'd0);
    check(oALU_OUT_M == 32'h0, {tag, "_out"}, oALU_OUT_M, 32'h0);
  endtask

  always @(negedge iCLK) begin
    exp_t e;
    bit expReady;
    if (running && !iRST) begin
      expReady = (cyc >= readyCyc);
      if (oVALID) begin
        check(sbQ.size() != 0, "unexpected_valid",
              oALU_OUT_M, 32'h0);
        if (sbQ.size() != 0) begin
          e = sbQ.pop_front();
          check(oALU_OUT_M == e.val, "result",
                oALU_OUT_M, e.val);
          check(cyc == e.cyc, "valid_cycle",
                32'(cyc), 32'(e.cyc));
          lastExp = e.val;
        end
      end else begin
        check(oALU_OUT_M == lastExp, "out_hold",
              oALU_OUT_M, lastExp);
        if (sbQ.size() != 0) begin
          check(cyc <= sbQ[0].cyc, "missing_valid",
                32'(cyc), 32'(sbQ[0].cyc));
          if (cyc > sbQ[0].cyc) void'(sbQ.pop_front());
        end
      end
      check(oREADY == expReady, "ready",
            32'(oREADY), 32'(expReady));
      check(oBUSY == !expReady, "busy",
            32'(oBUSY), 32'(!expReady));
    end
  end

  initial begin
    int t;
    int g;
    logic [2:0] f;
    logic [31:0] a, b;
    repeat (3) @(posedge iCLK);
    #1;
    iRST = 1'b0;
    readyCyc = cyc;
    running = 1'b1;
    rstChecks("reset");

    issue(3'd0, 32'd7, 32'hFFFF_FFFD, t);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, t);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, t);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, t);
    issue(3'd5, 32'd100, 32'd7, t);
    issue(3'd7, 32'd100, 32'd7, t);
    issue(3'd4, 32'd5, 32'd0, t);
    issue(3'd7, 32'd5, 32'd0, t);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, t);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, t);

    for (int i = 0; i < 40; i++) begin
      randOp(f, a, b);
      issue(f, a, b, t);
    end

    issue(3'd4, $urandom, 32'($urandom_range(1, 9999)), t);
    while (cyc < t + 10) begin
      @(posedge iCLK); #1;
    end
    iKILL = 1'b1;
    @(posedge iCLK); #1;
    iKILL = 1'b0;
    void'(sbQ.pop_back());
    readyCyc = cyc;
    repeat (40) @(posedge iCLK);
    issue(3'd0, 32'd3, 32'd4, t);

    @(posedge iCLK); #1;
    g = 0;
    while (!oREADY && g < 200) begin
      @(posedge iCLK); #1;
      g++;
    end
    iVALID = 1'b1;
    iKILL = 1'b1;
    iFUNCT3 = 3'd0;
    iALU_IN1_M = 32'd5;
    iALU_IN2_M = 32'd6;
    @(posedge iCLK); #1;
    iVALID = 1'b0;
    iKILL = 1'b0;
    repeat (3) @(posedge iCLK);

    stream(8);

    issue(3'd1, $urandom, $urandom, t);
    repeat (5) @(posedge iCLK);
    #1;
    iRST = 1'b1;
    @(posedge iCLK); #1;
    iRST = 1'b0;
    sbQ.delete();
    readyCyc = cyc;
    lastExp = '0;
    rstChecks("midrst");

    stream(6);
    for (int i = 0; i < 10; i++) begin
      randOp(f, a, b);
      issue(f, a, b, t);
    end

    g = 0;
    while (sbQ.size() != 0 && g < 200) begin
      @(posedge iCLK);
      g++;
    end
    check(sbQ.size() == 0, "drain_timeout",
          32'(sbQ.size()), 32'd0);
    repeat (3) @(posedge iCLK);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
